wb_collector: RTL
=================

Name: wb_collector

Overview:
- Sits directly downstream of the execute stage, between the functional-unit result buses (FLU, load, store, FPU) and the scoreboard writeback ports.
- The units have no writeback backpressure: they assert valid and expect the result to be taken that cycle.
- This block buffers each source in a small FIFO and drains up to NR_WB_PORTS results per cycle, with round-robin fairness.
- It raises an issue stall when any buffer nears full and flags overflow.

Parameters:
- NR_SRC, 4: number of result sources. Index 0=FLU, 1=load, 2=store, 3=FPU.
- NR_WB_PORTS, 2: number of scoreboard write ports driven per cycle. Must be ≤ NR_SRC.
- DEPTH, 2: entries per source FIFO. Must be ≥2 and a power of 2.
- TRANS_ID_BITS, 3: scoreboard tag width.
- XLEN, 64: result width.
- EXC_W, 129: packed exception width, {valid, cause[63:0], tval[63:0]}.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all buffered results.
- src_valid_i  in  NR_SRC  per-source result valid.
- src_trans_id_i  in  NR_SRC*TRANS_ID_BITS  per-source scoreboard tag; source i occupies slice i.
- src_result_i  in  NR_SRC*XLEN  per-source result.
- src_exc_i  in  NR_SRC*EXC_W  per-source exception.
- wb_valid_o  out  NR_WB_PORTS  writeback valid per port.
- wb_trans_id_o  out  NR_WB_PORTS*TRANS_ID_BITS  tag per port.
- wb_result_o  out  NR_WB_PORTS*XLEN  result per port.
- wb_exc_o  out  NR_WB_PORTS*EXC_W  exception per port.
- issue_stall_o  out  1  issue must hold new instructions.
- overflow_o  out  1  sticky error: a result was dropped.

Behaviour:
Reset (async, rst_ni low):
- All FIFOs empty; round-robin pointer = 0.
- All outputs = 0.

Enqueue:
- src_valid_i[i]=1 in cycle t writes {tag, result, exc} into FIFO i at the rising edge ending cycle t.
- Each FIFO is in-order; wrap-around pointers are log2(DEPTH) bits plus a count.

Drain, evaluated on registered FIFO state:
- Each cycle the arbiter scans sources starting at rr_ptr, cyclically.
- It grants the first min(NR_WB_PORTS, #non-empty) non-empty FIFOs.
- At most one entry per source per cycle.
- Grants map to ports in scan order: first grant → port 0.
- Granted heads are popped and registered onto wb_*_o.
- Output latency: a result enqueued in cycle t is visible on wb_valid_o in cycle t+1 at the earliest. There is no combinational bypass.
- Ports without a grant have wb_valid_o=0 and data held at 0.

Round-robin update:
- If any grant occurs, rr_ptr ← (index of last granted source + 1) mod NR_SRC.
- Otherwise rr_ptr is unchanged.

Simultaneous enqueue and dequeue on the same FIFO:
- Both take effect; count is unchanged.
- A full FIFO that is popped in the same cycle accepts the new entry.

Overflow:
- Condition: src_valid_i[i]=1 while FIFO i is full and not popped that cycle.
- The new entry is dropped and the FIFO is unchanged.
- overflow_o ← 1 and stays 1 until reset or flush.

issue_stall_o:
- Combinational from registered counts: 1 when any FIFO count ≥ DEPTH-1.

Flush:
- At the edge where flush_i=1: all FIFOs are emptied and rr_ptr ← 0.
- Inputs arriving in the flush cycle are discarded.
- wb_valid_o = 0 in cycle t+1.
- overflow_o ← 0.
- Flush has priority over enqueue and overflow.

Reset asserted mid-operation:
- Immediate clear as above.
- No writeback is emitted for entries buffered before reset.

Test Plan:
- Single FLU result: src_valid_i=4'b0001, tag=3, result=0xDEAD at cycle 0 → cycle 1: wb_valid_o=2'b01, wb_trans_id_o[0]=3, wb_result_o[0]=0xDEAD; cycle 2: wb_valid_o=0.
- Four sources valid in one cycle, tags 0..3 → cycle 1 ports carry tags 0,1 and rr_ptr=2; cycle 2 ports carry tags 2,3; cycle 3 nothing valid.
- Load valid for 3 consecutive cycles with FPU also valid each cycle (tags L=1,2,3 and F=4,5,6):
  - Both FIFOs drain one entry per cycle with no loss.
  - issue_stall_o=1 whenever a count reaches 1 (DEPTH-1) at the sample point.
  - overflow_o stays 0.
- Overflow: hold wb drain blocked by keeping 2 other sources busy, so the load FIFO fills to 2 without a pop, then load valid again → third entry dropped, overflow_o=1 the next cycle, and the two earlier tags still written back in order.
- Flush: 3 entries buffered, flush_i=1 in cycle t together with a new FLU result → wb_valid_o=0 from t+1, overflow_o=0, issue_stall_o=0, and a new result at t+1 appears at t+2 on port 0.
- Async reset pulse mid-drain → wb_valid_o=0 immediately, and there is no residual writeback after reset deasserts.

Source files
------------

// File: rtl/wb_collector.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : wb_collector
// Description : Writeback collector between the execute-stage result buses
//               (FLU, load, store, FPU) and the scoreboard write ports.
//               Each source is buffered in a small in-order FIFO. Up to
//               NR_WB_PORTS buffered heads are drained per cycle. A
//               round-robin pointer picks the scan start. The block asks
//               issue to stall when any buffer nears full. It keeps a
//               sticky flag when a result has to be dropped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i          in   clock
//   rst_ni         in   asynchronous active-low reset
//   flush_i        in   synchronous flush, discards every buffered result
//   src_valid_i    in   [NR_SRC]                 per-source result valid
//   src_trans_id_i in   [NR_SRC*TRANS_ID_BITS]   per-source scoreboard tag
//   src_result_i   in   [NR_SRC*XLEN]            per-source result
//   src_exc_i      in   [NR_SRC*EXC_W]           per-source exception
//   wb_valid_o     out  [NR_WB_PORTS]            writeback valid per port
//   wb_trans_id_o  out  [NR_WB_PORTS*TRANS_ID_BITS]
//   wb_result_o    out  [NR_WB_PORTS*XLEN]
//   wb_exc_o       out  [NR_WB_PORTS*EXC_W]
//   issue_stall_o  out  some FIFO holds at least DEPTH-1 entries
//   overflow_o     out  sticky: a result was dropped (cleared by flush/reset)
// ============================================================================
module wb_collector #(
  parameter int unsigned NR_SRC        = 4,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned EXC_W         = 129
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic [NR_SRC-1:0]                    src_valid_i,
  input  logic [NR_SRC*TRANS_ID_BITS-1:0]      src_trans_id_i,
  input  logic [NR_SRC*XLEN-1:0]               src_result_i,
  input  logic [NR_SRC*EXC_W-1:0]              src_exc_i,
  output logic [NR_WB_PORTS-1:0]               wb_valid_o,
  output logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [NR_WB_PORTS*XLEN-1:0]          wb_result_o,
  output logic [NR_WB_PORTS*EXC_W-1:0]         wb_exc_o,
  output logic                                 issue_stall_o,
  output logic                                 overflow_o
);

  // Entry layout: {trans_id, result, exception}
  localparam int unsigned ENTRY_W = TRANS_ID_BITS + XLEN + EXC_W;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned SRC_W   = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int unsigned GNT_W   = $clog2(NR_WB_PORTS + 1);

  logic [NR_SRC-1:0]      empty;
  logic [NR_SRC-1:0]      full;
  logic [NR_SRC-1:0]      near_full;
  logic [NR_SRC-1:0]      push;
  logic [NR_SRC-1:0]      pop;
  logic [NR_SRC-1:0]      drop;
  logic [ENTRY_W-1:0]     head [NR_SRC];

  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       last_src;
  logic                   any_grant;
  logic [NR_WB_PORTS-1:0] port_vld;
  logic [SRC_W-1:0]       port_src [NR_WB_PORTS];
  logic                   overflow_q;

  // --------------------------------------------------------------------------
  // Per-source FIFOs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NR_SRC; i++) begin : g_fifo
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [ENTRY_W-1:0] entry_in;

    assign entry_in = {src_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS],
                       src_result_i[i*XLEN +: XLEN],
                       src_exc_i[i*EXC_W +: EXC_W]};

    assign empty[i]     = (cnt == '0);
    assign full[i]      = (cnt == CNT_W'(DEPTH));
    assign near_full[i] = (cnt >= CNT_W'(DEPTH - 1));
    assign head[i]      = mem[rd_ptr];

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push[i] = src_valid_i[i] & ~flush_i & (~full[i] | pop[i]);
    assign drop[i] = src_valid_i[i] & full[i] & ~pop[i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[i])  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end

    // Payload storage needs no reset: occupancy is tracked by cnt alone.
    always_ff @(posedge clk_i) begin
      if (push[i]) mem[wr_ptr] <= entry_in;
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: cyclic scan from rr_ptr, the first non-empty
  // sources win ports in scan order, at most one pop per source.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [SRC_W:0]   idx_ext;
    logic [SRC_W-1:0] idx;
    logic [GNT_W-1:0] n_gnt;

    pop       = '0;
    port_vld  = '0;
    last_src  = rr_ptr;
    any_grant = 1'b0;
    n_gnt     = '0;
    idx_ext   = '0;
    idx       = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) port_src[p] = '0;

    for (int k = 0; k < NR_SRC; k++) begin
      idx_ext = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
      if (idx_ext >= (SRC_W + 1)'(NR_SRC)) idx_ext = idx_ext - (SRC_W + 1)'(NR_SRC);
      idx = idx_ext[SRC_W-1:0];
      if (!empty[idx] && (n_gnt < GNT_W'(NR_WB_PORTS))) begin
        for (int p = 0; p < NR_WB_PORTS; p++) begin
          if (n_gnt == GNT_W'(p)) begin
            port_vld[p] = 1'b1;
            port_src[p] = idx;
          end
        end
        pop[idx]  = 1'b1;
        last_src  = idx;
        any_grant = 1'b1;
        n_gnt     = n_gnt + GNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      rr_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (any_grant) begin
        rr_ptr <= (last_src == SRC_W'(NR_SRC - 1)) ? '0 : last_src + SRC_W'(1);
      end
      if (|drop) overflow_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Writeback ports: decoded from registered FIFO heads only, so a result
  // shows up the cycle after it was captured and never passes straight
  // through. Ungranted ports drive zero data.
  // --------------------------------------------------------------------------
  always_comb begin
    wb_valid_o    = port_vld;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_exc_o      = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      for (int s = 0; s < NR_SRC; s++) begin
        if (port_vld[p] && (port_src[p] == SRC_W'(s))) begin
          wb_trans_id_o[p*TRANS_ID_BITS +: TRANS_ID_BITS] = head[s][EXC_W+XLEN +: TRANS_ID_BITS];
          wb_result_o[p*XLEN +: XLEN]                     = head[s][EXC_W +: XLEN];
          wb_exc_o[p*EXC_W +: EXC_W]                      = head[s][EXC_W-1:0];
        end
      end
    end
  end

  assign issue_stall_o = |near_full;
  assign overflow_o    = overflow_q;

endmodule
`default_nettype wire
